perceptron_frame_driver: RTL

Front-end sequencer for the perceptron classifier.
- Collects one 5x5 binary image as a serial pixel stream, 1 bit per cycle, row-major, with a valid/ready handshake.
- Presents the image as a stable parallel word on p_in and drives p_en through one full classify pass.
- Captures the class code when the perceptron's combinational ready asserts, then returns {class, error} over a valid/ready result handshake.
- The perceptron has no reset, so this block owns re-synchronising the perceptron's internal step counter.

---
 rtl/perceptron_pkg.sv | 19 +
 rtl/pixel_frame_loader.sv | 65 ++++++
 rtl/perceptron_frame_driver.sv | 131 +++++++++++++
 3 files changed

// File: rtl/perceptron_pkg.sv
// Shared class codes, sequencer states and sizing defaults for the perceptron front end.
package perceptron_pkg;

  localparam int WIDTH_DEF = 25;

  localparam logic [1:0] CLASS_NONE   = 2'b00;
  localparam logic [1:0] CLASS_CIRCLE = 2'b01;
  localparam logic [1:0] CLASS_CROSS  = 2'b10;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  // Worst case is one discarded stale pass plus one full pass.
  function automatic int timeout_for(input int width);
    return 2 * width + 2;
  endfunction

  localparam int TIMEOUT_DEF = 2 * WIDTH_DEF + 2;

endpackage

// File: rtl/pixel_frame_loader.sv
// Serial-to-parallel frame capture: pixel index, p_in write/clear and frame length check.
module pixel_frame_loader
  import perceptron_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic             pix_data,
  input  logic             pix_last,
  input  logic             clear,
  output logic [WIDTH-1:0] p_in,
  output logic             frame_done,
  output logic             len_err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] p_in_q, p_in_d;
  logic             len_err_q, len_err_d;
  logic             at_end;

  assign at_end     = (idx_q == IW'(WIDTH - 1));
  assign frame_done = accept && (pix_last || at_end);

  always_comb begin
    idx_d     = idx_q;
    p_in_d    = p_in_q;
    len_err_d = len_err_q;
    if (clear) begin
      idx_d     = '0;
      p_in_d    = '0;
      len_err_d = 1'b0;
    end else if (accept) begin
      p_in_d[idx_q] = pix_data;
      idx_d         = idx_q + 1'b1;
      if (frame_done) begin
        idx_d = '0;
        // An early pix_last leaves the tail of the image undefined; force it to 0.
        for (int k = 0; k < WIDTH; k++) begin
          if (k > int'(idx_q)) p_in_d[k] = 1'b0;
        end
        if (pix_last != at_end) len_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      p_in_q    <= '0;
      len_err_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      p_in_q    <= p_in_d;
      len_err_q <= len_err_d;
    end
  end

  assign p_in    = p_in_q;
  assign len_err = len_err_q;

endmodule

// File: rtl/perceptron_frame_driver.sv
// Frame sequencer for the reset-less perceptron: IDLE/LOAD collect pixels, RUN enables one
// aligned classify pass (re-aligning the perceptron counter when needed), DONE holds the result.
module perceptron_frame_driver
  import perceptron_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = timeout_for(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  input  logic             pix_data,
  input  logic             pix_last,
  output logic             pix_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [1:0]       res_class,
  output logic             res_err,
  output logic [WIDTH-1:0] p_in,
  output logic             p_en,
  input  logic [1:0]       p_out,
  input  logic             p_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_PASS = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_TO   = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] run_cnt_q, run_cnt_d;
  logic          synced_q, synced_d;
  logic          pix_ready_q, pix_ready_d;
  logic          p_en_q, p_en_d;
  logic          res_valid_q, res_valid_d;
  logic [1:0]    res_class_q, res_class_d;
  logic          res_err_q, res_err_d;
  logic          accept, frame_done, len_err, clear;

  assign accept = pix_valid && pix_ready_q;
  assign clear  = (state_q == DONE) && res_ready;

  pixel_frame_loader #(.WIDTH(WIDTH)) u_loader (
    .clk        (clk),
    .rst        (rst),
    .accept     (accept),
    .pix_data   (pix_data),
    .pix_last   (pix_last),
    .clear      (clear),
    .p_in       (p_in),
    .frame_done (frame_done),
    .len_err    (len_err)
  );

  always_comb begin
    state_d     = state_q;
    run_cnt_d   = run_cnt_q;
    synced_d    = synced_q;
    res_class_d = res_class_q;
    res_err_d   = res_err_q;
    case (state_q)
      IDLE: begin
        run_cnt_d = '0;
        if (accept) state_d = frame_done ? RUN : LOAD;
      end
      LOAD: begin
        run_cnt_d = '0;
        if (frame_done) state_d = RUN;
      end
      RUN: begin
        run_cnt_d = run_cnt_q + 1'b1;
        // A strobe exactly at WIDTH proves the perceptron counter started this pass at 0.
        if (p_ready && run_cnt_q == CNT_PASS) begin
          state_d     = DONE;
          synced_d    = 1'b1;
          res_class_d = p_out;
          res_err_d   = len_err || (p_out == 2'b11);
        end else if (p_ready && synced_q) begin
          state_d     = DONE;
          synced_d    = 1'b0;
          res_class_d = CLASS_NONE;
          res_err_d   = 1'b1;
        end else if (p_ready && run_cnt_q != '0) begin
          // Perceptron wraps to 0 on this edge; restart the pass from there.
          synced_d  = 1'b1;
          run_cnt_d = '0;
        end else if (run_cnt_q == CNT_TO) begin
          state_d     = DONE;
          synced_d    = 1'b0;
          res_class_d = CLASS_NONE;
          res_err_d   = 1'b1;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    pix_ready_d = (state_d == IDLE) || (state_d == LOAD);
    p_en_d      = (state_d == RUN);
    res_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      run_cnt_q   <= '0;
      synced_q    <= 1'b0;
      pix_ready_q <= 1'b0;
      p_en_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_class_q <= CLASS_NONE;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      synced_q    <= synced_d;
      pix_ready_q <= pix_ready_d;
      p_en_q      <= p_en_d;
      res_valid_q <= res_valid_d;
      res_class_q <= res_class_d;
      res_err_q   <= res_err_d;
    end
  end

  assign pix_ready = pix_ready_q;
  assign p_en      = p_en_q;
  assign res_valid = res_valid_q;
  assign res_class = res_class_q;
  assign res_err   = res_err_q;

endmodule
